// File: rtl/matmul_2x2_arb_ctrl.sv
// Round-robin front end for the shared 2x2 matrix-multiply engine: accepts one
// job at a time from two requesters, sequences the engine and returns C to the owner.
module matmul_2x2_arb_ctrl #(
    parameter int DATA_W      = 8,
    parameter int ACC_W       = 32,
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [4*DATA_W-1:0] req0_a,
    input  logic [4*DATA_W-1:0] req0_b,
    output logic                rsp0_valid,
    input  logic                rsp0_ready,
    output logic [4*ACC_W-1:0]  rsp0_c,
    output logic                rsp0_err,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [4*DATA_W-1:0] req1_a,
    input  logic [4*DATA_W-1:0] req1_b,
    output logic                rsp1_valid,
    input  logic                rsp1_ready,
    output logic [4*ACC_W-1:0]  rsp1_c,
    output logic                rsp1_err,
    output logic                eng_start,
    output logic [4*DATA_W-1:0] eng_a,
    output logic [4*DATA_W-1:0] eng_b,
    input  logic [4*ACC_W-1:0]  eng_c,
    input  logic                eng_done,
    output logic                busy,
    output logic [CNT_W-1:0]    jobs_done
);

    localparam int TO_W = $clog2(TIMEOUT_CYC);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [4*DATA_W-1:0]   a_q, a_d;
    logic [4*DATA_W-1:0]   b_q, b_d;
    logic [4*ACC_W-1:0]    res_q, res_d;
    logic                  err_q, err_d;
    logic                  owner_q, owner_d;
    logic                  last_grant_q, last_grant_d;
    logic [TO_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]      jobs_q, jobs_d;
    logic                  winner1;
    logic                  owner_rsp_ready;

    // Requester 1 wins when alone, or on a tie when requester 0 was granted last.
    assign winner1    = req1_valid & (~req0_valid | ~last_grant_q);
    assign req0_ready = (state_q == S_IDLE) & req0_valid & ~winner1;
    assign req1_ready = (state_q == S_IDLE) & req1_valid & winner1;

    assign owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        res_d        = res_q;
        err_d        = err_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        jobs_d       = jobs_q;
        eng_start    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req0_ready | req1_ready) begin
                    a_d          = winner1 ? req1_a : req0_a;
                    b_d          = winner1 ? req1_b : req0_b;
                    owner_d      = winner1;
                    last_grant_d = winner1;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                eng_start = 1'b1;
                cnt_d     = '0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (eng_done) begin
                    res_d   = eng_c;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == TO_LAST) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                if (owner_rsp_ready) begin
                    jobs_d  = jobs_q + 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            err_q        <= 1'b0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            jobs_q       <= '0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            res_q        <= res_d;
            err_q        <= err_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            jobs_q       <= jobs_d;
        end
    end

    assign eng_a      = a_q;
    assign eng_b      = b_q;
    assign busy       = (state_q != S_IDLE);
    assign jobs_done  = jobs_q;
    assign rsp0_valid = (state_q == S_RESP) & ~owner_q;
    assign rsp1_valid = (state_q == S_RESP) & owner_q;
    assign rsp0_c     = owner_q ? '0 : res_q;
    assign rsp1_c     = owner_q ? res_q : '0;
    assign rsp0_err   = ~owner_q & err_q;
    assign rsp1_err   = owner_q & err_q;

endmodule

// File: tb/tb_matmul_2x2_arb_ctrl.sv
// Self-checking bench for matmul_2x2_arb_ctrl with a behavioural engine whose
// latency can be set per job, or told never to finish.
module tb_matmul_2x2_arb_ctrl;

    localparam int DW = 8;
    localparam int AW = 32;
    localparam int NV = 7;

    typedef logic [4*AW-1:0] wide_t;
    typedef logic [4*DW-1:0] op_t;

    typedef struct {
        int   rid;
        op_t  a;
        op_t  b;
        int   lat;
        bit   never;
        bit   err;
        int   exp_lat;
        wide_t c;
    } vec_t;

    typedef struct {
        int    rid;
        wide_t c;
        logic  err;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    logic  req0_valid = 1'b0, req1_valid = 1'b0;
    logic  req0_ready, req1_ready;
    op_t   req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic  rsp0_valid, rsp1_valid;
    logic  rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    wide_t rsp0_c, rsp1_c;
    logic  rsp0_err, rsp1_err;
    logic  eng_start;
    op_t   eng_a, eng_b;
    wide_t eng_c;
    logic  eng_done;
    logic  busy;
    logic [15:0] jobs_done;

    int    tests = 0;
    int    failed = 0;
    int    jobs_exp = 0;
    int    starts_exp = 0;
    int    start_cnt = 0;
    exp_t  sb[$];
    vec_t  vecs[NV];

    int    eng_lat = 1;
    bit    eng_never = 1'b0;
    logic  stray_done = 1'b0;
    logic  eng_done_r;
    wide_t eng_c_r;
    op_t   ea, eb;
    int    ecnt;

    always #5 clk = ~clk;

    matmul_2x2_arb_ctrl #(
        .DATA_W(DW), .ACC_W(AW), .TIMEOUT_CYC(16), .CNT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_c(rsp0_c), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_c(rsp1_c), .rsp1_err(rsp1_err),
        .eng_start(eng_start), .eng_a(eng_a), .eng_b(eng_b), .eng_c(eng_c), .eng_done(eng_done),
        .busy(busy), .jobs_done(jobs_done)
    );

    function automatic wide_t matmul(input op_t a, input op_t b);
        wide_t c;
        int    s;
        c = '0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                s = 0;
                for (int k = 0; k < 2; k++)
                    s += int'($signed(a[(2*i+k)*DW +: DW])) * int'($signed(b[(2*k+j)*DW +: DW]));
                c[(2*i+j)*AW +: AW] = s;
            end
        end
        return c;
    endfunction

    // Engine: done is a one-cycle pulse lat edges after it sees start.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_done_r <= 1'b0;
            eng_c_r    <= '0;
            ecnt       <= 0;
        end else begin
            eng_done_r <= 1'b0;
            if (eng_start) begin
                ecnt <= eng_never ? 0 : eng_lat;
                ea   <= eng_a;
                eb   <= eng_b;
            end else if (ecnt == 1) begin
                eng_done_r <= 1'b1;
                eng_c_r    <= matmul(ea, eb);
                ecnt       <= 0;
            end else if (ecnt > 1) begin
                ecnt <= ecnt - 1;
            end
        end
    end
    assign eng_done = eng_done_r | stray_done;
    assign eng_c    = eng_c_r;

    always @(posedge clk) if (eng_start === 1'b1) start_cnt <= start_cnt + 1;

    task automatic check(input string name, input wide_t act, input wide_t exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int rid, input op_t a, input op_t b, input int lat,
                                input bit never, input bit err, input int exp_lat);
        vec_t v;
        v.rid = rid; v.a = a; v.b = b; v.lat = lat; v.never = never;
        v.err = err; v.exp_lat = exp_lat;
        v.c = err ? '0 : matmul(a, b);
        return v;
    endfunction

    function automatic exp_t mk_exp(input int rid, input wide_t c, input logic err);
        exp_t e;
        e.rid = rid; e.c = c; e.err = err;
        return e;
    endfunction

    // Returns at the negedge of the ISSUE cycle, with the request dropped.
    task automatic drive_req(input int rid, input op_t a, input op_t b, input string tag);
        int n = 0;
        @(negedge clk);
        if (rid == 0) begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
        else          begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
        #1;
        while (!(rid == 0 ? req0_ready : req1_ready) && n < 100) begin
            @(negedge clk); #1; n++;
        end
        check({tag, "_accept"}, wide_t'(rid == 0 ? req0_ready : req1_ready), 1);
        @(negedge clk);
        if (rid == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        starts_exp++;
        check({tag, "_start"}, wide_t'(eng_start), 1);
        check({tag, "_eng_ab"}, wide_t'({eng_a, eng_b}), wide_t'({a, b}));
    endtask

    // Called from the ISSUE cycle; exp_lat counts cycles from ISSUE to rsp_valid.
    task automatic collect(input int exp_lat, input int hold, input string tag);
        exp_t  e;
        int    n = 0;
        wide_t c_act;
        while (!(rsp0_valid | rsp1_valid) && n < 300) begin @(negedge clk); n++; end
        if (sb.size() == 0) begin
            tests++; failed++;
            $display("FAIL %s_sb: response with empty scoreboard", tag);
            return;
        end
        e = sb.pop_front();
        check({tag, "_valid"}, wide_t'({rsp1_valid, rsp0_valid}), wide_t'(e.rid == 0 ? 2'b01 : 2'b10));
        if (exp_lat > 0) check({tag, "_latency"}, wide_t'(n), wide_t'(exp_lat));
        c_act = (e.rid == 0) ? rsp0_c : rsp1_c;
        check({tag, "_c"}, c_act, e.c);
        check({tag, "_err"}, wide_t'(e.rid == 0 ? rsp0_err : rsp1_err), wide_t'(e.err));
        for (int h = 0; h < hold; h++) begin
            stray_done = 1'b1;
            @(negedge clk);
            stray_done = 1'b0;
            check({tag, "_hold_c"}, (e.rid == 0) ? rsp0_c : rsp1_c, c_act);
            check({tag, "_hold_state"}, wide_t'({busy, rsp1_valid, rsp0_valid, req1_ready, req0_ready}),
                  wide_t'({1'b1, e.rid == 1, e.rid == 0, 2'b00}));
        end
        if (e.rid == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
        @(negedge clk);
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        jobs_exp++;
        check({tag, "_idle"}, wide_t'({busy, rsp1_valid, rsp0_valid}), 0);
        check({tag, "_jobs"}, wide_t'(jobs_done), wide_t'(jobs_exp));
        check({tag, "_starts"}, wide_t'(start_cnt), wide_t'(starts_exp));
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        eng_lat = v.lat; eng_never = v.never;
        sb.push_back(mk_exp(v.rid, v.c, v.err));
        drive_req(v.rid, v.a, v.b, tag);
        collect(v.exp_lat, 0, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        op_t   neg = 32'h80808080;
        op_t   a0  = 32'h04030201;
        op_t   b0  = 32'h08070605;
        int    seen;

        vecs[0] = mk(0, a0, b0, 3, 1'b0, 1'b0, 5);
        vecs[0].c = {32'd50, 32'd43, 32'd22, 32'd19};
        vecs[1] = mk(1, 32'hFF058007, 32'h7F8102FD, 1, 1'b0, 1'b0, 3);
        vecs[2] = mk(0, 32'h01010101, 32'h02020202, 1, 1'b1, 1'b1, 17);
        vecs[3] = mk(0, 32'h11223344, 32'hF0E0D0C0, 2, 1'b0, 1'b0, 4);
        vecs[4] = mk(1, 32'h05FB7F80, 32'h807F03FD, 15, 1'b0, 1'b0, 17);
        vecs[5] = mk(1, 32'h09080706, 32'h01020304, 16, 1'b0, 1'b1, 17);
        vecs[6] = mk(0, 32'h7F7F7F7F, neg, 4, 1'b0, 1'b0, 6);

        #3;
        check("reset_outputs", wide_t'({busy, eng_start, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err,
              req0_ready, req1_ready}), 0);
        check("reset_regs", wide_t'({eng_a, eng_b, jobs_done}), 0);
        check("reset_c", rsp0_c | rsp1_c, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Tie straight after reset: requester 0 first, then requester 1.
        eng_lat = 2; eng_never = 1'b0;
        @(negedge clk);
        req0_valid = 1'b1; req0_a = a0;  req0_b = b0;
        req1_valid = 1'b1; req1_a = neg; req1_b = neg;
        #1;
        check("tie1_ready", wide_t'({req1_ready, req0_ready}), 2'b01);
        sb.push_back(mk_exp(0, vecs[0].c, 1'b0));
        sb.push_back(mk_exp(1, {4{32'd32768}}, 1'b0));
        @(negedge clk);
        req0_valid = 1'b0;
        starts_exp++;
        check("tie1_eng_a", wide_t'(eng_a), wide_t'(a0));
        collect(4, 0, "tie1_r0");
        check("tie1_r1_ready", wide_t'({req1_ready, req0_ready}), 2'b10);
        @(negedge clk);
        req1_valid = 1'b0;
        starts_exp++;
        check("tie1_r1_eng_a", wide_t'(eng_a), wide_t'(neg));
        collect(4, 0, "tie1_r1");

        @(negedge clk);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("tie2_ready", wide_t'({req1_ready, req0_ready}), 2'b01);
        sb.push_back(mk_exp(0, vecs[0].c, 1'b0));
        sb.push_back(mk_exp(1, {4{32'd32768}}, 1'b0));
        @(negedge clk);
        req0_valid = 1'b0;
        starts_exp++;
        collect(4, 0, "tie2_r0");
        @(negedge clk);
        req1_valid = 1'b0;
        starts_exp++;
        collect(4, 0, "tie2_r1");

        for (int i = 0; i < NV; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Stray done while idle.
        @(negedge clk);
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        @(negedge clk);
        check("stray_idle", wide_t'({busy, rsp1_valid, rsp0_valid}), 0);
        check("stray_idle_starts", wide_t'(start_cnt), wide_t'(starts_exp));

        // Response back-pressure with requester 1 waiting.
        eng_lat = 3; eng_never = 1'b0;
        sb.push_back(mk_exp(0, matmul(32'h03FD02FE, 32'h7F017F01), 1'b0));
        drive_req(0, 32'h03FD02FE, 32'h7F017F01, "bp_r0");
        req1_valid = 1'b1; req1_a = 32'h01020304; req1_b = 32'h05060708;
        sb.push_back(mk_exp(1, matmul(32'h01020304, 32'h05060708), 1'b0));
        collect(5, 10, "bp_r0");
        check("bp_r1_ready", wide_t'({req1_ready, req0_ready}), 2'b10);
        @(negedge clk);
        req1_valid = 1'b0;
        starts_exp++;
        check("bp_r1_start", wide_t'(eng_start), 1);
        collect(5, 0, "bp_r1");

        // Asynchronous reset during WAIT drops the job.
        eng_never = 1'b1;
        drive_req(0, 32'h01010101, 32'h01010101, "rst_job");
        repeat (5) @(negedge clk);
        check("rst_pre_busy", wide_t'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_outputs", wide_t'({busy, eng_start, rsp0_valid, rsp1_valid, rsp0_err,
              req0_ready, req1_ready}), 0);
        check("rst_async_regs", wide_t'({eng_a, eng_b, jobs_done}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        jobs_exp = 0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (rsp0_valid | rsp1_valid | busy) seen++;
        end
        check("rst_no_response", wide_t'(seen), 0);
        run_vec(vecs[0], "post_rst");
        check("post_rst_sb_empty", wide_t'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
